// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: one shared prescaler and period counter,
// per-channel double-buffered duty registers, edge- or center-aligned counting.
module pwm_multi_ch #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned RES      = 8,
    parameter int unsigned PRESCALE = 16
) (
    input  logic                clk_50M,
    input  logic                reset,
    input  logic                en,
    input  logic                mode,
    input  logic                wr_en,
    input  logic [3:0]          wr_ch,
    input  logic [RES-1:0]      wr_duty,
    output logic                wr_err,
    output logic                tick,
    output logic                period_start,
    output logic [CHANNELS-1:0] pwm_out
);

    localparam int unsigned    PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [RES-1:0] CNT_MAX = {RES{1'b1}};

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [PW-1:0]       presc_q, presc_d;
    logic [RES-1:0]      cnt_q, cnt_d;
    dir_e                dir_q, dir_d;
    logic                mode_q, mode_d;
    logic [RES-1:0]      shadow_q [CHANNELS];
    logic [RES-1:0]      shadow_d [CHANNELS];
    logic [RES-1:0]      active_q [CHANNELS];
    logic [RES-1:0]      active_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                tick_q, period_start_q, wr_err_q;
    logic                tick_c, boundary_c, wr_err_c;

    // State register; reset overrides enable, writes and boundary updates.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            dir_q          <= DIR_UP;
            mode_q         <= 1'b0;
            pwm_q          <= '0;
            tick_q         <= 1'b0;
            period_start_q <= 1'b0;
            wr_err_q       <= 1'b0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            dir_q          <= dir_d;
            mode_q         <= mode_d;
            pwm_q          <= pwm_d;
            tick_q         <= tick_c;
            period_start_q <= boundary_c;
            wr_err_q       <= wr_err_c;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
        end
    end

    // Next-state: prescaler, period counter, duty buffering and PWM compare.
    always_comb begin
        presc_d    = presc_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        mode_d     = mode_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        tick_c     = 1'b0;
        boundary_c = 1'b0;
        wr_err_c   = wr_en && (32'(wr_ch) >= CHANNELS);
        pwm_d      = '0;

        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (wr_en && (wr_ch == 4'(i))) begin
                shadow_d[i] = wr_duty;
            end
        end

        if (!en) begin
            // Idle: park at the start of a period, track shadows and mode live.
            presc_d  = '0;
            cnt_d    = '0;
            dir_d    = DIR_UP;
            mode_d   = mode;
            active_d = shadow_q;
        end else begin
            tick_c  = (presc_q == PRE_MAX);
            presc_d = tick_c ? '0 : presc_q + PW'(1);
            if (tick_c) begin
                if (mode_q == 1'b0) begin
                    cnt_d      = cnt_q + RES'(1);
                    boundary_c = (cnt_q == CNT_MAX);
                end else if (dir_q == DIR_UP) begin
                    if (cnt_q == CNT_MAX) begin
                        dir_d = DIR_DOWN;
                        cnt_d = cnt_q - RES'(1);
                    end else begin
                        cnt_d = cnt_q + RES'(1);
                    end
                end else begin
                    cnt_d = cnt_q - RES'(1);
                    if (cnt_q == RES'(1)) begin
                        dir_d      = DIR_UP;
                        boundary_c = 1'b1;
                    end
                end
                // Shadow_q (not shadow_d) so a same-cycle write lands next period.
                if (boundary_c) begin
                    active_d = shadow_q;
                    mode_d   = mode;
                end
            end
            for (int i = 0; i < int'(CHANNELS); i++) begin
                pwm_d[i] = (active_q[i] == CNT_MAX) || (cnt_q < active_q[i]);
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign tick         = tick_q;
    assign period_start = period_start_q;
    assign wr_err       = wr_err_q;

endmodule
